// File: rtl/ring_pkg.sv
// Shared definitions for the main-ring memory station: slot type codes,
// Address-word layout, token length field and the station FSM states.
package ring_pkg;

    localparam logic [3:0] SLOT_TOKEN      = 4'd1;
    localparam logic [3:0] SLOT_ADDRESS    = 4'd2;
    localparam logic [3:0] SLOT_WRITE_DATA = 4'd3;
    localparam logic [3:0] SLOT_NULL       = 4'd7;

    localparam int ADDR_RD_BIT     = 28;
    localparam int ADDR_RESEND_BIT = 31;

    localparam int TOKEN_LEN_LSB = 0;
    localparam int TOKEN_LEN_MSB = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_INSERT
    } stationState_t;

    // Fresh request word: resend bit low, read flag and line address.
    function automatic logic [31:0] addrWord(
        input logic        rd,
        input logic [25:0] addr
    );
        logic [31:0] w;
        w                  = '0;
        w[25:0]            = addr;
        w[ADDR_RD_BIT]     = rd;
        w[ADDR_RESEND_BIT] = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/ring_word_fifo.sv
// Synchronous 32-bit FIFO with show-ahead read data and occupancy count.
// Ports: push/pushData write side, pop/popData read side, count = occupancy.
module ring_word_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [31:0]                pushData,
    input  logic                       pop,
    output logic [31:0]                popData,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    // Pushes into a full FIFO are dropped, pops of an empty one ignored.
    assign doPush  = push & (count != CW'(DEPTH));
    assign doPop   = pop & (count != '0);
    assign popData = mem[rdPtr];

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= (wrPtr == PW'(DEPTH - 1)) ? '0 : wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr <= (rdPtr == PW'(DEPTH - 1)) ? '0 : rdPtr + PW'(1);
            end
            unique case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ring_mem_station.sv
// Ring station ahead of the memory mux: forwards slots with one cycle of
// delay, attaches one pending read/write per token pass, collects read data.
// Ports: Ring*/SlotType*/SrcDest* ring in/out, RD* read return, req_* core
// request, wd_* write data push, rd_* read data to core, proto_err sticky.
module ring_mem_station
    import ring_pkg::*;
#(
    parameter logic [3:0] MY_ID       = 4'd1,
    parameter int         WRITE_WORDS = 8,
    parameter int         READ_WORDS  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] RingIn,
    input  logic [3:0]  SlotTypeIn,
    input  logic [3:0]  SrcDestIn,
    output logic [31:0] RingOut,
    output logic [3:0]  SlotTypeOut,
    output logic [3:0]  SrcDestOut,
    input  logic [31:0] RDreturn,
    input  logic [3:0]  RDdest,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [25:0] req_addr,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        proto_err
);

    localparam int             FCW         = $clog2(WRITE_WORDS + 1);
    localparam logic [FCW-1:0] FIFO_FULL   = FCW'(WRITE_WORDS);
    localparam logic [7:0]     WRITE_SLOTS = 8'(WRITE_WORDS + 1);
    localparam logic [7:0]     LAST_BEAT   = 8'(READ_WORDS - 1);

    stationState_t state;
    stationState_t stateNext;

    logic [7:0]  cnt;
    logic [7:0]  cntNext;
    logic [7:0]  nIns;
    logic [7:0]  nNext;
    logic [7:0]  idx;
    logic [7:0]  idxNext;
    logic [31:0] ringNext;
    logic [3:0]  typeNext;
    logic [3:0]  sdNext;
    logic        fifoPop;
    logic        insertDone;
    logic        dropErr;

    logic        pending;
    logic        pendWrite;
    logic [25:0] pendAddr;
    logic        rdBusy;
    logic [7:0]  rdCnt;
    logic        beat;

    logic [FCW-1:0] fifoCount;
    logic [31:0]    fifoData;

    logic [7:0] tokenLen;
    logic [7:0] reqLen;
    logic [7:0] grant;
    logic [8:0] lenSum;

    ring_word_fifo #(
        .DEPTH (WRITE_WORDS)
    ) u_wfifo (
        .clock    (clock),
        .reset    (reset),
        .push     (wd_valid),
        .pushData (wd_data),
        .pop      (fifoPop),
        .popData  (fifoData),
        .count    (fifoCount)
    );

    assign wd_ready = (fifoCount != FIFO_FULL);

    // A write is only accepted once its whole burst sits in the FIFO.
    assign req_ready = ~reset & ~pending & ~rdBusy
                     & (~req_write | (fifoCount == FIFO_FULL));

    assign beat = (RDdest == MY_ID);

    // Slots this station wants to add on the current token; withheld
    // entirely if the grown length would not fit in the 8-bit field.
    assign tokenLen = RingIn[TOKEN_LEN_MSB:TOKEN_LEN_LSB];
    assign reqLen   = pending ? (pendWrite ? WRITE_SLOTS : 8'd1) : 8'd0;
    assign lenSum   = {1'b0, tokenLen} + {1'b0, reqLen};
    assign grant    = lenSum[8] ? 8'd0 : reqLen;

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        nNext      = nIns;
        idxNext    = idx;
        ringNext   = RingIn;
        typeNext   = SlotTypeIn;
        sdNext     = SrcDestIn;
        fifoPop    = 1'b0;
        insertDone = 1'b0;
        dropErr    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (SlotTypeIn == SLOT_TOKEN) begin
                    ringNext = {RingIn[31:8], tokenLen + grant};
                    cntNext  = tokenLen;
                    nNext    = grant;
                    idxNext  = 8'd0;
                    if (tokenLen != 8'd0) begin
                        stateNext = ST_PASS;
                    end else if (grant != 8'd0) begin
                        stateNext = ST_INSERT;
                    end
                end
            end
            ST_PASS: begin
                cntNext = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    stateNext = (nIns != 8'd0) ? ST_INSERT : ST_IDLE;
                end
            end
            ST_INSERT: begin
                sdNext  = MY_ID;
                dropErr = (SlotTypeIn != SLOT_NULL);
                if (idx == 8'd0) begin
                    typeNext = SLOT_ADDRESS;
                    ringNext = addrWord(~pendWrite, pendAddr);
                end else begin
                    typeNext = SLOT_WRITE_DATA;
                    ringNext = fifoData;
                    fifoPop  = 1'b1;
                end
                idxNext = idx + 8'd1;
                if (idx == nIns - 8'd1) begin
                    insertDone = 1'b1;
                    stateNext  = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            nIns        <= 8'd0;
            idx         <= 8'd0;
            RingOut     <= 32'd0;
            SlotTypeOut <= SLOT_NULL;
            SrcDestOut  <= 4'd0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            nIns        <= nNext;
            idx         <= idxNext;
            RingOut     <= ringNext;
            SlotTypeOut <= typeNext;
            SrcDestOut  <= sdNext;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending   <= 1'b0;
            pendWrite <= 1'b0;
            pendAddr  <= 26'd0;
            rdBusy    <= 1'b0;
            rdCnt     <= 8'd0;
            rd_valid  <= 1'b0;
            rd_data   <= 32'd0;
            rd_last   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            rd_valid <= beat & rdBusy;
            rd_last  <= beat & rdBusy & (rdCnt == LAST_BEAT);
            if (beat & rdBusy) begin
                rd_data <= RDreturn;
                if (rdCnt == LAST_BEAT) begin
                    rdBusy <= 1'b0;
                    rdCnt  <= 8'd0;
                end else begin
                    rdCnt <= rdCnt + 8'd1;
                end
            end
            if (dropErr | (beat & ~rdBusy)) begin
                proto_err <= 1'b1;
            end
            if (insertDone) begin
                pending <= 1'b0;
            end
            // Acceptance needs rdBusy and pending low, so it never
            // collides with the clears above.
            if (req_valid & req_ready) begin
                pending   <= 1'b1;
                pendWrite <= req_write;
                pendAddr  <= req_addr;
                if (!req_write) begin
                    rdBusy <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ring_mem_station.sv
// Self-checking bench for ring_mem_station: randomized ring, request and
// read-return traffic against a slot-list reference model.
module tb_ring_mem_station;

    localparam logic [3:0] MY_ID = 4'd1;
    localparam int         WW    = 8;
    localparam int         RW    = 8;

    typedef struct packed {
        logic [3:0]  t;
        logic [3:0]  sd;
        logic [31:0] d;
    } slot_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] RingIn;
    logic [3:0]  SlotTypeIn;
    logic [3:0]  SrcDestIn;
    logic [31:0] RingOut;
    logic [3:0]  SlotTypeOut;
    logic [3:0]  SrcDestOut;
    logic [31:0] RDreturn;
    logic [3:0]  RDdest;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [25:0] req_addr;
    logic        wd_valid;
    logic        wd_ready;
    logic [31:0] wd_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    bit          mPending;
    bit          mWrite;
    logic [25:0] mAddr;
    logic [31:0] mFifo [$];
    bit          mRdBusy;
    int          mRdCnt;
    bit          mErr;

    slot_t inQ  [$];
    slot_t expQ [$];

    always #5 clock = ~clock;

    ring_mem_station #(
        .MY_ID       (MY_ID),
        .WRITE_WORDS (WW),
        .READ_WORDS  (RW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .RingIn      (RingIn),
        .SlotTypeIn  (SlotTypeIn),
        .SrcDestIn   (SrcDestIn),
        .RingOut     (RingOut),
        .SlotTypeOut (SlotTypeOut),
        .SrcDestOut  (SrcDestOut),
        .RDreturn    (RDreturn),
        .RDdest      (RDdest),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .wd_valid    (wd_valid),
        .wd_ready    (wd_ready),
        .wd_data     (wd_data),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .proto_err   (proto_err)
    );

    task automatic driveNull();
        RingIn     = 32'd0;
        SlotTypeIn = 4'd7;
        SrcDestIn  = 4'd0;
    endtask

    task automatic modelReset();
        mPending = 0;
        mWrite   = 0;
        mAddr    = '0;
        mFifo.delete();
        mRdBusy  = 0;
        mRdCnt   = 0;
        mErr     = 0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        wd_valid  = 1'b0;
        wd_data   = '0;
        RDdest    = 4'd0;
        RDreturn  = '0;
        RingIn     = 32'hDEAD_0101;
        SlotTypeIn = 4'd1;
        SrcDestIn  = 4'd5;
        repeat (3) @(negedge clock);
        checks++;
        if ({SlotTypeOut, SrcDestOut, RingOut} !== {4'd7, 4'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_ring: got %h/%h/%h want 7/0/0",
                     SlotTypeOut, SrcDestOut, RingOut);
        end
        checks++;
        if ({req_ready, rd_valid, rd_last, proto_err, wd_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_ctl: got rr=%b rv=%b rl=%b pe=%b wr=%b want 0 0 0 0 1",
                     req_ready, rd_valid, rd_last, proto_err, wd_ready);
        end
        driveNull();
        reset = 1'b0;
        modelReset();
        @(negedge clock);
    endtask

    task automatic pushWords(input int k, input bit seq, input logic [31:0] base);
        for (int i = 0; i < k; i++) begin
            @(negedge clock);
            wd_valid = 1'b1;
            wd_data  = seq ? base + 32'(i) : $urandom();
            #1;
            checks++;
            if (wd_ready !== (mFifo.size() < WW)) begin
                errors++;
                $display("FAIL wd_ready: got %b want %b (fifo %0d)",
                         wd_ready, mFifo.size() < WW, mFifo.size());
            end
            if (mFifo.size() < WW) mFifo.push_back(wd_data);
        end
        @(negedge clock);
        wd_valid = 1'b0;
    endtask

    task automatic request(input bit wr, input logic [25:0] addr, input string nm);
        bit exp;
        @(negedge clock);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        #1;
        exp = !mPending && !mRdBusy && (!wr || mFifo.size() == WW);
        checks++;
        if (req_ready !== exp) begin
            errors++;
            $display("FAIL %s req_ready: got %b want %b", nm, req_ready, exp);
        end
        if (exp) begin
            mPending = 1;
            mWrite   = wr;
            mAddr    = addr;
            if (!wr) mRdBusy = 1;
        end
        @(negedge clock);
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    // Builds the whole expected output stream for one token pass and
    // compares it slot by slot, one cycle behind the input.
    task automatic runToken(input logic [7:0] L, input int errAt, input string nm);
        slot_t s;
        int    n;
        logic [31:0] hi;
        inQ.delete();
        expQ.delete();
        n = mPending ? (mWrite ? 1 + WW : 1) : 0;
        if (int'(L) + n > 255) n = 0;
        hi     = $urandom();
        s.t    = 4'd1;
        s.sd   = 4'($urandom_range(0, 15));
        s.d    = {hi[31:8], L};
        inQ.push_back(s);
        s.d    = {hi[31:8], 8'(int'(L) + n)};
        expQ.push_back(s);
        for (int i = 0; i < int'(L); i++) begin
            s.t  = 4'($urandom_range(0, 15));
            if (s.t == 4'd1) s.t = 4'd2;
            s.sd = 4'($urandom_range(0, 15));
            s.d  = $urandom();
            inQ.push_back(s);
            expQ.push_back(s);
        end
        for (int i = 0; i < n; i++) begin
            s.t  = (i == errAt) ? 4'd8 : 4'd7;
            s.sd = 4'd0;
            s.d  = (i == errAt) ? 32'h5555_AAAA : 32'd0;
            if (i == errAt) mErr = 1;
            inQ.push_back(s);
            s.sd = MY_ID;
            if (i == 0) begin
                s.t = 4'd2;
                s.d = (mWrite ? 32'd0 : 32'h1000_0000) | {6'd0, mAddr};
            end else begin
                s.t = 4'd3;
                s.d = mFifo.pop_front();
            end
            expQ.push_back(s);
        end
        if (n != 0) mPending = 0;
        for (int i = 0; i <= inQ.size(); i++) begin
            @(negedge clock);
            if (i > 0) begin
                checks++;
                if ({SlotTypeOut, SrcDestOut, RingOut} !== expQ[i-1]) begin
                    errors++;
                    $display("FAIL %s slot%0d: got %h/%h/%h want %h/%h/%h", nm, i - 1,
                             SlotTypeOut, SrcDestOut, RingOut,
                             expQ[i-1].t, expQ[i-1].sd, expQ[i-1].d);
                end
            end
            if (i < inQ.size()) begin
                RingIn     = inQ[i].d;
                SlotTypeIn = inQ[i].t;
                SrcDestIn  = inQ[i].sd;
            end else begin
                driveNull();
            end
        end
        checks++;
        if (proto_err !== mErr) begin
            errors++;
            $display("FAIL %s proto_err: got %b want %b", nm, proto_err, mErr);
        end
    endtask

    task automatic readBeats(input int nBeats, input bit foreign, input string nm);
        logic [3:0]  dq [$];
        bit          eV;
        bit          eL;
        bit          eR;
        logic [31:0] eD;
        for (int j = 0; j < nBeats; j++) begin
            if (foreign && $urandom_range(0, 2) == 0) dq.push_back(4'($urandom_range(2, 15)));
            dq.push_back(MY_ID);
        end
        eV = 0; eL = 0; eR = 0; eD = '0;
        for (int i = 0; i <= dq.size(); i++) begin
            @(negedge clock);
            if (i > 0) begin
                checks++;
                if (rd_valid !== eV || rd_last !== eL || (eV && rd_data !== eD)) begin
                    errors++;
                    $display("FAIL %s beat%0d: got v=%b l=%b d=%h want v=%b l=%b d=%h",
                             nm, i - 1, rd_valid, rd_last, rd_data, eV, eL, eD);
                end
                checks++;
                if (req_ready !== eR || proto_err !== mErr) begin
                    errors++;
                    $display("FAIL %s ready%0d: got rr=%b pe=%b want rr=%b pe=%b",
                             nm, i - 1, req_ready, proto_err, eR, mErr);
                end
            end
            if (i < dq.size()) begin
                RDdest   = dq[i];
                RDreturn = $urandom();
                eD = RDreturn;
                eV = (dq[i] == MY_ID) && mRdBusy;
                eL = eV && (mRdCnt == RW - 1);
                if (dq[i] == MY_ID && !mRdBusy) mErr = 1;
                if (eV) begin
                    if (eL) begin
                        mRdBusy = 0;
                        mRdCnt  = 0;
                    end else begin
                        mRdCnt++;
                    end
                end
                eR = !mPending && !mRdBusy;
            end else begin
                RDdest = 4'd0;
            end
        end
    endtask

    task automatic test_passthrough();
        runToken(8'd3, -1, "pass_L3");
        runToken(8'd0, -1, "pass_L0");
        runToken(8'($urandom_range(1, 6)), -1, "pass_rand");
    endtask

    task automatic test_read();
        request(1'b0, 26'h000123, "read_req");
        request(1'b0, 26'h000456, "read_busy");
        runToken(8'd0, -1, "read_tok");
        request(1'b0, 26'h000789, "read_busy2");
        readBeats(RW, 1'b1, "read_ret");
    endtask

    task automatic test_write();
        pushWords(5, 1'b1, 32'hA0);
        request(1'b1, 26'h3FF, "write_early");
        pushWords(5, 1'b1, 32'hA5);
        request(1'b1, 26'h3FF, "write_req");
        runToken(8'd2, -1, "write_tok");
    endtask

    task automatic test_overflow();
        pushWords(WW, 1'b0, 32'd0);
        request(1'b1, 26'($urandom()), "ovf_req");
        runToken(8'd250, -1, "ovf_250");
        runToken(8'd0, -1, "ovf_0");
        pushWords(WW, 1'b0, 32'd0);
        request(1'b1, 26'($urandom()), "edge_req");
        runToken(8'd246, -1, "edge_246");
        request(1'b0, 26'($urandom()), "rd255_req");
        runToken(8'd255, -1, "rd_255");
        runToken(8'd254, -1, "rd_254");
        readBeats(RW, 1'b0, "rd254_ret");
    endtask

    task automatic test_proto_err();
        pushWords(WW, 1'b0, 32'd0);
        request(1'b1, 26'($urandom()), "perr_req");
        runToken(8'd0, 3, "perr_tok");
        runToken(8'd1, -1, "perr_sticky");
        test_reset();
        readBeats(1, 1'b0, "stray_beat");
    endtask

    task automatic test_reset_mid_insert();
        logic [31:0] hi;
        logic [31:0] w;
        pushWords(WW, 1'b1, 32'hC0);
        request(1'b1, 26'h00ABC, "rst_req");
        hi = $urandom();
        @(negedge clock);
        RingIn     = {hi[31:8], 8'd0};
        SlotTypeIn = 4'd1;
        SrcDestIn  = 4'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            driveNull();
            checks++;
            if (i == 0) begin
                if ({SlotTypeOut, RingOut} !== {4'd1, hi[31:8], 8'd9}) begin
                    errors++;
                    $display("FAIL rst_tok: got %h/%h want 1/%h", SlotTypeOut, RingOut,
                             {hi[31:8], 8'd9});
                end
            end else if (i == 1) begin
                if ({SlotTypeOut, SrcDestOut, RingOut} !== {4'd2, MY_ID, 32'h0000_0ABC}) begin
                    errors++;
                    $display("FAIL rst_addr: got %h/%h/%h want 2/1/00000abc",
                             SlotTypeOut, SrcDestOut, RingOut);
                end
            end else begin
                w = mFifo.pop_front();
                if ({SlotTypeOut, SrcDestOut, RingOut} !== {4'd3, MY_ID, w}) begin
                    errors++;
                    $display("FAIL rst_wd%0d: got %h/%h/%h want 3/1/%h", i - 2,
                             SlotTypeOut, SrcDestOut, RingOut, w);
                end
            end
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({SlotTypeOut, RingOut, req_ready} !== {4'd7, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_out: got %h/%h rr=%b want 7/0 rr=0",
                     SlotTypeOut, RingOut, req_ready);
        end
        reset = 1'b0;
        modelReset();
        req_write = 1'b1;
        #1;
        checks++;
        if ({req_ready, wd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rst_fifo: got rr=%b wr=%b want rr=0 wr=1", req_ready, wd_ready);
        end
        req_write = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_pending: got rr=%b want 1", req_ready);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        bit wr;
        for (int it = 0; it < 8; it++) begin
            wr = 1'($urandom_range(0, 1));
            if (wr) pushWords(WW, 1'b0, 32'd0);
            request(wr, 26'($urandom()), "b2b_req");
            runToken(8'($urandom_range(0, 8)), -1, "b2b_tok");
            runToken(8'($urandom_range(0, 3)), -1, "b2b_idle");
            if (!wr) readBeats(RW, 1'b1, "b2b_ret");
        end
    endtask

    initial begin
        driveNull();
        modelReset();
        test_reset();
        test_passthrough();
        test_read();
        test_write();
        test_overflow();
        test_back_to_back();
        test_reset_mid_insert();
        test_proto_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
